// File: rtl/ll_free_list.sv
// ll_free_list: free-slot pointer queue for the shared linked-list FIFO.
// Optional macro FREE_LIST_BYPASS_EN: allocate the slot being freed while empty.
module ll_free_list #(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc,
    input  logic                 free,
    input  logic [PTR_WIDTH-1:0] free_ptr,
    output logic [PTR_WIDTH-1:0] alloc_ptr,
    output logic                 empty,
    output logic                 full,
    output logic [PTR_WIDTH:0]   count,
    output logic                 err_underflow,
    output logic                 err_overflow
);

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] ONE       = (PTR_WIDTH+1)'(1);

    logic [PTR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic                 err_underflow_q, err_underflow_d;
    logic                 err_overflow_q, err_overflow_d;

    logic bypass;
    logic alloc_ok;
    logic free_ok;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

`ifdef FREE_LIST_BYPASS_EN
    assign bypass = alloc && free && empty;
`else
    assign bypass = 1'b0;
`endif

    assign alloc_ok = alloc && !empty;
    // A free into a full list is fine when the same edge also allocates.
    assign free_ok  = free && (!full || alloc_ok) && !bypass;

    assign alloc_ptr = bypass ? free_ptr : mem_q[rd_ptr_q[PTR_WIDTH-1:0]];

    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;

    always_comb begin
        mem_d           = mem_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        err_underflow_d = err_underflow_q;
        err_overflow_d  = err_overflow_q;
        if (alloc_ok) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        if (free_ok) begin
            mem_d[wr_ptr_q[PTR_WIDTH-1:0]] = free_ptr;
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (alloc && empty && !bypass) begin
            err_underflow_d = 1'b1;
        end
        if (free && full && !alloc_ok) begin
            err_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PTR_WIDTH'(i);
            end
            rd_ptr_q        <= '0;
            wr_ptr_q        <= DEPTH_CNT;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
        end else begin
            mem_q           <= mem_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            err_underflow_q <= err_underflow_d;
            err_overflow_q  <= err_overflow_d;
        end
    end

`ifdef FORMAL
    always @(posedge clk) begin
        if (!rst) begin
            assert (count <= DEPTH_CNT);
        end
    end
`endif

endmodule

// File: doc/ll_free_list.md
Name: ll_free_list

Overview:
- Free-slot pointer manager for the shared linked-list FIFO.
- Holds the indices of unused data/next-pointer slots in a circular-pointer queue.
- Hands out one slot per push (alloc) and takes back the old head slot on each pop (free).
- Sits directly beside the shared FIFO's push/pop path. Its alloc_ptr is the slot the shared FIFO writes on a push; its free_ptr is the head slot the shared FIFO releases on a pop.

Parameters:
- DEPTH, 4: number of slots; must be a power of 2, at least 2.
- PTR_WIDTH, $clog2(DEPTH): slot index width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- alloc  input  1  consume the head free slot this cycle (shared-FIFO push).
- free  input  1  return free_ptr to the list this cycle (shared-FIFO pop).
- free_ptr  input  PTR_WIDTH  slot index being returned; sampled only when free=1.
- alloc_ptr  output  PTR_WIDTH  slot index granted on alloc; first-word fall-through, combinational from list head.
- empty  output  1  no free slots (count==0).
- full  output  1  every slot free (count==DEPTH).
- count  output  PTR_WIDTH+1  number of free slots.
- err_underflow  output  1  sticky: an illegal alloc occurred.
- err_overflow  output  1  sticky: an illegal free occurred.

Behaviour:
- Storage: mem[DEPTH] of PTR_WIDTH bits, plus rd_ptr and wr_ptr, each PTR_WIDTH+1 bits.
- Pointers wrap modulo 2*DEPTH; the low PTR_WIDTH bits index mem.
- count = wr_ptr - rd_ptr, computed in PTR_WIDTH+1 bits, unsigned.
- empty = (count==0); full = (count==DEPTH).
- alloc_ptr = mem[rd_ptr[PTR_WIDTH-1:0]]. It reflects current-cycle state; the value is not defined when empty.
- Reset (rst=1 at posedge), overriding all other inputs:
  - mem[i] <= i for every i.
  - rd_ptr <= 0, wr_ptr <= DEPTH.
  - Both err flags cleared.
  - Post-reset outputs: count=DEPTH, full=1, empty=0, alloc_ptr=0.
- Legal alloc (alloc=1 and not empty): rd_ptr += 1 at the clock edge.
- Legal free (free=1 and not full): mem[wr_ptr] <= free_ptr, and wr_ptr += 1.
- Simultaneous alloc and free:
  - Each operation is judged against pre-edge state.
  - A free while full is legal if alloc is also legal that cycle.
  - When full, both pointers index the same mem entry. alloc_ptr shows the old contents; the write lands after the read. Net count is unchanged.
  - An alloc while empty is always illegal, even with a simultaneous free, unless the optional feature is compiled in.
- Illegal alloc (alloc=1 and empty): rd_ptr holds and err_underflow <= 1. A simultaneous legal free still proceeds.
- Illegal free (free=1, full, and no legal alloc): wr_ptr and mem hold, and err_overflow <= 1.
- Err flags stay sticky until rst.
- Latency: alloc_ptr for the next grant is valid in the cycle after the edge that moved rd_ptr. A returned slot is allocatable one cycle after its free edge.
- Reset mid-operation: any in-flight alloc or free in the reset cycle is discarded, and the list is fully repopulated.
- Duplicate free_ptr values are not detected. Slot uniqueness is the shared FIFO's responsibility.
- Formal hook: always-block assertion (under `FORMAL) that count <= DEPTH.

Optional Feature:
- Macro: FREE_LIST_BYPASS_EN.
- Defined:
  - When empty with alloc=1 and free=1, the cycle is legal.
  - alloc_ptr = free_ptr combinationally; neither pointer nor mem changes; no error flag is set.
  - alloc_ptr muxes free_ptr only in this case.
- Undefined:
  - The same cycle sets err_underflow.
  - The free is still performed: mem[wr_ptr] <= free_ptr, wr_ptr += 1, so count goes 0->1.
  - alloc_ptr is a pure mem read.

Test Plan:
- DEPTH=4, rst for 1 cycle -> count=4, full=1, empty=0, alloc_ptr=0; four back-to-back allocs grant 0,1,2,3, then empty=1, count=0.
- From empty, free 2 then free 0, then alloc twice -> alloc_ptr=2 then 0; count goes 0,1,2,1,0.
- Full list, alloc=1 and free=1 with free_ptr=3 -> alloc_ptr=0 granted, count stays 4, no err. Three further allocs give 1,2,3, and the fourth gives 3 (from the wrapped write).
- Full list, free=1 alone -> err_overflow=1 next cycle, count=4, mem unchanged. Empty list, alloc=1 -> err_underflow=1, count=0. Both flags stay set until rst.
- Empty list, alloc=1, free=1, free_ptr=1:
  - With FREE_LIST_BYPASS_EN: alloc_ptr=1 that cycle, count stays 0, no err.
  - Without it: err_underflow=1 and count=1.
- Two allocs, then assert rst in the same cycle as alloc=1 and free=1 -> next cycle count=4, alloc_ptr=0, err flags 0, and the grant order restarts 0,1,2,3.
